data_mem_wait: RTL

- Parametrised successor to the single-cycle data memory in the MEM stage of the ARM pipeline.
- Adds configurable wait states with a ready handshake so the hazard/freeze logic can stall the pipeline.
- Adds byte (LDRB/STRB) and word access, plus a fault flag for misaligned, out-of-range or conflicting requests.
- Word storage is little-endian; the array is word-addressed internally.

---
 rtl/data_mem_wait.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_wait.sv
// Purpose: word/byte data memory for the MEM stage with configurable wait states and a fault flag.
// Latency: a request sampled in IDLE completes with a one-cycle ready pulse WAIT_CYCLES+1 cycles later.
// Backpressure: requester holds its request until ready; inputs are only sampled in IDLE.
`timescale 1ns/1ps

module data_mem_wait #(
  parameter int DATA_WIDTH  = 32,  // byte lanes assume 4 bytes per word
  parameter int DEPTH       = 64,  // words; power of two, >= 2
  parameter int WAIT_CYCLES = 2    // extra wait states, 0..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  byte_mode,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] mem_result,
  output logic                  ready,
  output logic                  fault
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state;
  logic [3:0]            count;

  // Request captured at the IDLE sampling edge
  logic                  lat_rd;
  logic                  lat_wr;
  logic                  lat_byte;
  logic [31:0]           lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;

  // Storage: word addressed, deliberately not reset
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Request fields as seen at the commit edge. With no wait states the
  // commit edge is the sampling edge itself, so the live inputs are used.
  logic                  src_rd;
  logic                  src_wr;
  logic                  src_byte;
  logic [31:0]           src_addr;
  logic [DATA_WIDTH-1:0] src_data;

  logic                  req;
  logic                  commit;
  logic                  src_conflict;
  logic                  src_misalign;
  logic                  src_range;
  logic                  src_fault;
  logic [AW-1:0]         src_idx;
  logic [1:0]            src_lane;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [DATA_WIDTH-1:0] next_result;
  logic                  mem_we;

  assign req = mem_read | mem_write;

  // Select the request source: live inputs in IDLE, latched copy otherwise
  always_comb begin
    src_rd   = lat_rd;
    src_wr   = lat_wr;
    src_byte = lat_byte;
    src_addr = lat_addr;
    src_data = lat_data;
    if (state == S_IDLE) begin
      src_rd   = mem_read;
      src_wr   = mem_write;
      src_byte = byte_mode;
      src_addr = address;
      src_data = data;
    end
  end

  // The edge entering DONE: from IDLE when there are no wait states, else the last WAIT cycle
  always_comb begin
    commit = 1'b0;
    if (rst) begin
      if (state == S_IDLE && req && NO_WAIT) begin
        commit = 1'b1;
      end else if (state == S_WAIT && count == 4'd1) begin
        commit = 1'b1;
      end
    end
  end

  // Decode address, classify faults and form the load result
  always_comb begin
    src_idx      = src_addr[AW+1:2];
    src_lane     = src_addr[1:0];
    src_conflict = src_rd & src_wr;
    src_misalign = ~src_byte & (src_lane != 2'b00);
    src_range    = |src_addr[31:AW+2];
    src_fault    = src_conflict | src_misalign | src_range;
    rd_word      = mem[src_idx];
    case (src_lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    next_result = '0;
    if (!src_fault && !src_wr) begin
      next_result = src_byte ? {{(DATA_WIDTH-8){1'b0}}, rd_byte} : rd_word;
    end
    mem_we = commit & src_wr & ~src_fault;
  end

  // Array update at the commit edge; byte stores touch only their lane
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (src_byte) begin
        mem[src_idx][{src_lane, 3'b000} +: 8] <= src_data[7:0];
      end else begin
        mem[src_idx] <= src_data;
      end
    end
  end

  // Control FSM with registered ready/fault/result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      count      <= 4'd0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      mem_result <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_byte   <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
    end else begin
      ready <= 1'b0;
      if (commit) begin
        ready      <= 1'b1;
        fault      <= src_fault;
        mem_result <= next_result;
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_rd   <= mem_read;
            lat_wr   <= mem_write;
            lat_byte <= byte_mode;
            lat_addr <= address;
            lat_data <= data;
            count    <= WAIT_LD;
            state    <= NO_WAIT ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Request is not re-sampled here; one idle cycle separates accesses
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
